// File: rtl/cbd_byte_feeder.sv
// ---------------------------------------------------------------------------
// cbd_byte_feeder
//
// Transmitter side of the CBD byte-stream interface. Accepts SHAKE256 squeeze
// blocks (RATE_BYTES wide) and serializes them into BEAT_BYTES-wide beats on a
// valid/ready handshake toward the cbd sampler. One polynomial needs 128 bytes
// (eta=2, 16 beats, one block) or 192 bytes (eta=3, 24 beats, two blocks);
// bytes beyond that are discarded.
//
// Ports:
//   i_clk, i_rstn    clock, asynchronous active-low reset
//   i_start, i_eta   start pulse and eta (2 or 3) sampled with it
//   i_blk            squeeze block, byte 0 in the top byte lane
//   i_blk_valid      squeeze block valid
//   o_blk_ready      feeder takes i_blk this cycle (only while requesting)
//   o_ibytes         output beat, first stream byte in [63:56]
//   o_ibytes_valid   output beat valid
//   i_ibytes_ready   cbd accepts the beat
//   o_busy           polynomial in progress
//   o_done           one-cycle pulse after the last beat is accepted
//   o_err            (CBD_FEED_ERR_EN only) sticky bad-start flag
//
// Optional feature macro: CBD_FEED_ERR_EN
//   Defined:   invalid eta or i_start while busy sets o_err; an invalid-eta
//              start is refused. o_err clears on the next accepted start.
//   Undefined: no o_err port; invalid eta is treated as 2 and a start while
//              busy is silently ignored.
// ---------------------------------------------------------------------------
module cbd_byte_feeder #(
  parameter int RATE_BYTES = 136,
  parameter int BEAT_BYTES = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_start,
  input  logic [1:0]                i_eta,
  input  logic [RATE_BYTES*8-1:0]   i_blk,
  input  logic                      i_blk_valid,
  output logic                      o_blk_ready,
  output logic [BEAT_BYTES*8-1:0]   o_ibytes,
  output logic                      o_ibytes_valid,
  input  logic                      i_ibytes_ready,
  output logic                      o_busy,
`ifdef CBD_FEED_ERR_EN
  output logic                      o_err,
`endif
  output logic                      o_done
);

  localparam int BLK_W  = RATE_BYTES * 8;
  localparam int BEAT_W = BEAT_BYTES * 8;
  localparam int BEATS_PER_BLK = RATE_BYTES / BEAT_BYTES;
  localparam logic [4:0] LAST_WBEAT = 5'(BEATS_PER_BLK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         eta_q, eta_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [4:0]         wcnt_q, wcnt_d;
  logic [4:0]         tcnt_q, tcnt_d;
  logic               valid_q, valid_d;
  logic [4:0]         last_tbeat;
  logic               beat_xfer;
`ifdef CBD_FEED_ERR_EN
  logic               err_q, err_d;
  logic               eta_ok;

  assign eta_ok = (i_eta == 2'd2) || (i_eta == 2'd3);
`endif

  assign last_tbeat = (eta_q == 2'd3) ? 5'd23 : 5'd15;
  assign beat_xfer  = valid_q && i_ibytes_ready;

  // The block register is a shift register: the current beat always sits in
  // the top lane, so o_ibytes comes straight from flops and holds steady
  // while the sampler stalls.
  always_comb begin
    state_d = state_q;
    eta_d   = eta_q;
    blk_d   = blk_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    valid_d = valid_q;
`ifdef CBD_FEED_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
`ifdef CBD_FEED_ERR_EN
          if (eta_ok) begin
            eta_d   = i_eta;
            err_d   = 1'b0;
            wcnt_d  = 5'd0;
            tcnt_d  = 5'd0;
            state_d = REQ;
          end else begin
            err_d   = 1'b1;
          end
`else
          eta_d   = (i_eta == 2'd3) ? 2'd3 : 2'd2;
          wcnt_d  = 5'd0;
          tcnt_d  = 5'd0;
          state_d = REQ;
`endif
        end
      end
      REQ: begin
        if (i_blk_valid) begin
          blk_d   = i_blk;
          wcnt_d  = 5'd0;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat_xfer) begin
          tcnt_d = tcnt_q + 5'd1;
          wcnt_d = wcnt_q + 5'd1;
          blk_d  = blk_q << BEAT_W;
          if (tcnt_q == last_tbeat) begin
            valid_d = 1'b0;
            state_d = DONE;
          end else if (wcnt_q == LAST_WBEAT) begin
            valid_d = 1'b0;
            state_d = REQ;
          end
        end
      end
      DONE: begin
        wcnt_d  = 5'd0;
        tcnt_d  = 5'd0;
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
`ifdef CBD_FEED_ERR_EN
    // A start that arrives mid-operation is flagged but otherwise ignored.
    if (i_start && (state_q != IDLE)) begin
      err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      eta_q   <= 2'd2;
      blk_q   <= '0;
      wcnt_q  <= 5'd0;
      tcnt_q  <= 5'd0;
      valid_q <= 1'b0;
`ifdef CBD_FEED_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      eta_q   <= eta_d;
      blk_q   <= blk_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      valid_q <= valid_d;
`ifdef CBD_FEED_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign o_ibytes       = blk_q[BLK_W-1 -: BEAT_W];
  assign o_ibytes_valid = valid_q;
  assign o_blk_ready    = (state_q == REQ);
  assign o_busy         = (state_q == REQ) || (state_q == SEND);
  assign o_done         = (state_q == DONE);
`ifdef CBD_FEED_ERR_EN
  assign o_err          = err_q;
`endif

endmodule

// File: tb/tb_cbd_byte_feeder.sv
// ---------------------------------------------------------------------------
// tb_cbd_byte_feeder
//
// Scoreboard bench for cbd_byte_feeder. applyStimulus builds the squeeze
// blocks for one polynomial, derives the expected byte stream from them
// (first 128 bytes for eta=2; 136 bytes of block 0 then 56 of block 1 for
// eta=3), packs it into beats and queues those. A block driver and a ready
// driver feed the DUT; a monitor pops and compares every accepted beat and
// watches handshake rules, o_done timing and block handshake counts.
// ---------------------------------------------------------------------------
module tb_cbd_byte_feeder;

  logic          i_clk;
  logic          i_rstn;
  logic          i_start;
  logic [1:0]    i_eta;
  logic [1087:0] i_blk;
  logic          i_blk_valid;
  logic          o_blk_ready;
  logic [63:0]   o_ibytes;
  logic          o_ibytes_valid;
  logic          i_ibytes_ready;
  logic          o_busy;
  logic          o_done;

  cbd_byte_feeder dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_start        (i_start),
    .i_eta          (i_eta),
    .i_blk          (i_blk),
    .i_blk_valid    (i_blk_valid),
    .o_blk_ready    (o_blk_ready),
    .o_ibytes       (o_ibytes),
    .o_ibytes_valid (o_ibytes_valid),
    .i_ibytes_ready (i_ibytes_ready),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  // Scoreboard and shared bookkeeping
  logic [63:0]   exp_q[$];
  logic [1087:0] blk_fifo[$];
  int            gap_fifo[$];
  int            gap_cnt;
  bit            blk_taken;
  int            beats_left;
  int            exp_blocks;
  int            blk_hs;
  bit            expect_done;
  bit            stall_pending;
  logic [63:0]   stall_val;
  bit            req_pending;
  int            rdy_mode;
  int            rdy_cyc;
  int            n_cmp;
  int            n_fail;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // One comparison: count it, report it on mismatch
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1087:0] make_block(input bit rnd, input int base);
    logic [1087:0] b;
    b = '0;
    for (int k = 0; k < 136; k++) begin
      b[1087-8*k -: 8] = rnd ? 8'($urandom_range(0, 255)) : 8'(base + k);
    end
    return b;
  endfunction

  // Queue one polynomial's expected beats and blocks, start it, wait for done
  task automatic applyStimulus(input logic [1:0] eta_in, input logic [1087:0] b0,
                               input logic [1087:0] b1, input int gap1,
                               input bit extra_start, input bit mid_reset);
    logic [7:0]  stream[$];
    logic [63:0] beat;
    int          nbytes;
    bit          eta3;
    bit          got;
    eta3   = (eta_in == 2'd3);
    nbytes = eta3 ? 192 : 128;
    for (int k = 0; k < 136; k++) stream.push_back(b0[1087-8*k -: 8]);
    for (int k = 0; k < 136; k++) stream.push_back(b1[1087-8*k -: 8]);
    for (int i = 0; i < nbytes / 8; i++) begin
      for (int j = 0; j < 8; j++) beat[63-8*j -: 8] = stream[8*i+j];
      exp_q.push_back(beat);
    end
    beats_left = nbytes / 8;
    exp_blocks = eta3 ? 2 : 1;
    blk_hs     = 0;
    if (blk_fifo.size() == 0) gap_cnt = 0;
    blk_fifo.push_back(b0);
    gap_fifo.push_back(0);
    if (eta3) begin
      blk_fifo.push_back(b1);
      gap_fifo.push_back(gap1);
    end
    @(posedge i_clk); #1;
    i_start = 1'b1;
    i_eta   = eta_in;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(negedge i_clk);
    checkOutput("busy_after_start", 64'(o_busy), 64'd1);
    if (extra_start) begin
      repeat (4) @(negedge i_clk);
      @(posedge i_clk); #1;
      i_start = 1'b1;
      i_eta   = 2'd3;
      @(posedge i_clk); #1;
      i_start = 1'b0;
    end
    if (mid_reset) begin
      got = 1'b0;
      for (int c = 0; c < 500; c++) begin
        @(negedge i_clk);
        if (beats_left <= 11) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        n_cmp++; n_fail++;
        $display("[TB] FAIL reset_wait: got timeout, expected 5 beats");
      end
      @(posedge i_clk); #1;
      i_rstn = 1'b0;
      #1;
      checkOutput("rst_ibytes", o_ibytes, 64'd0);
      checkOutput("rst_valid", 64'(o_ibytes_valid), 64'd0);
      checkOutput("rst_blk_ready", 64'(o_blk_ready), 64'd0);
      checkOutput("rst_busy", 64'(o_busy), 64'd0);
      checkOutput("rst_done", 64'(o_done), 64'd0);
      exp_q.delete();
      blk_fifo.delete();
      gap_fifo.delete();
      gap_cnt       = 0;
      blk_taken     = 1'b0;
      beats_left    = 0;
      expect_done   = 1'b0;
      stall_pending = 1'b0;
      req_pending   = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      i_rstn = 1'b1;
    end else begin
      got = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge i_clk);
        if (o_done) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        n_cmp++; n_fail++;
        $display("[TB] FAIL done_timeout: got no o_done, expected one (eta=%0d)", eta_in);
      end else begin
        checkOutput("busy_at_done", 64'(o_busy), 64'd0);
        checkOutput("beats_outstanding", 64'(exp_q.size()), 64'd0);
      end
    end
  endtask

  // Block driver: offers the front block once its gap (counted in requesting
  // cycles) has elapsed, retires it after a handshake.
  initial begin : blk_driver
    forever begin
      @(posedge i_clk); #1;
      if (blk_taken) begin
        blk_taken = 1'b0;
        if (blk_fifo.size() > 0) begin
          void'(blk_fifo.pop_front());
          void'(gap_fifo.pop_front());
        end
        gap_cnt = (gap_fifo.size() > 0) ? gap_fifo[0] : 0;
      end
      if (blk_fifo.size() > 0 && gap_cnt == 0) begin
        i_blk       = blk_fifo[0];
        i_blk_valid = 1'b1;
      end else begin
        i_blk_valid = 1'b0;
        if (gap_cnt > 0 && o_blk_ready) gap_cnt--;
      end
    end
  end

  // Ready driver: always, 1-0-0-1 pattern, or random 75 %
  initial begin : rdy_driver
    forever begin
      @(posedge i_clk); #1;
      rdy_cyc++;
      case (rdy_mode)
        1:       i_ibytes_ready = ((rdy_cyc % 4) == 0) || ((rdy_cyc % 4) == 3);
        2:       i_ibytes_ready = ($urandom_range(0, 3) != 0);
        default: i_ibytes_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares beats against the scoreboard and checks handshake rules
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge i_clk);
      if (i_rstn) begin
        checkOutput("done", 64'(o_done), 64'(expect_done));
        if (expect_done) checkOutput("blk_handshakes", 64'(blk_hs), 64'(exp_blocks));
        expect_done = 1'b0;
        if (stall_pending) begin
          checkOutput("stall_valid", 64'(o_ibytes_valid), 64'd1);
          checkOutput("stall_data", o_ibytes, stall_val);
        end
        if (o_blk_ready) checkOutput("no_beat_in_req", 64'(o_ibytes_valid), 64'd0);
        if (req_pending) checkOutput("blk_ready_held", 64'(o_blk_ready), 64'd1);
        if (o_ibytes_valid && i_ibytes_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("[TB] FAIL extra_beat: got %h, expected no beat", o_ibytes);
          end else begin
            e = exp_q.pop_front();
            checkOutput("beat", o_ibytes, e);
            beats_left--;
            if (beats_left == 0) expect_done = 1'b1;
          end
        end
        stall_pending = o_ibytes_valid && !i_ibytes_ready;
        stall_val     = o_ibytes;
        req_pending   = o_blk_ready && !i_blk_valid;
        if (o_blk_ready && i_blk_valid) begin
          blk_hs++;
          blk_taken = 1'b1;
        end
      end
    end
  end

  initial begin : main
    logic [1087:0] b0, b1;
    n_cmp = 0; n_fail = 0;
    gap_cnt = 0; blk_taken = 1'b0; beats_left = 0; exp_blocks = 0; blk_hs = 0;
    expect_done = 1'b0; stall_pending = 1'b0; req_pending = 1'b0; stall_val = '0;
    rdy_mode = 0; rdy_cyc = 0;
    i_rstn = 1'b0; i_start = 1'b0; i_eta = 2'd2; i_blk = '0; i_blk_valid = 1'b0;
    i_ibytes_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset_ibytes", o_ibytes, 64'd0);
    checkOutput("reset_valid", 64'(o_ibytes_valid), 64'd0);
    checkOutput("reset_blk_ready", 64'(o_blk_ready), 64'd0);
    checkOutput("reset_busy", 64'(o_busy), 64'd0);
    checkOutput("reset_done", 64'(o_done), 64'd0);
    i_rstn = 1'b1;
    repeat (2) @(posedge i_clk);

    $display("[TB] basic eta=2 / eta=3");
    applyStimulus(2'd2, make_block(1'b0, 0), '0, 0, 1'b0, 1'b0);
    applyStimulus(2'd3, make_block(1'b0, 0), make_block(1'b0, 'h88), 0, 1'b0, 1'b0);

    $display("[TB] backpressure");
    rdy_mode = 1;
    applyStimulus(2'd2, make_block(1'b1, 0), '0, 0, 1'b0, 1'b0);
    applyStimulus(2'd3, make_block(1'b1, 0), make_block(1'b1, 0), 0, 1'b0, 1'b0);

    $display("[TB] block starvation");
    rdy_mode = 0;
    applyStimulus(2'd3, make_block(1'b1, 0), make_block(1'b1, 0), 10, 1'b0, 1'b0);

    $display("[TB] start while busy, invalid eta");
    applyStimulus(2'd2, make_block(1'b1, 0), '0, 0, 1'b1, 1'b0);
    applyStimulus(2'd0, make_block(1'b1, 0), '0, 0, 1'b0, 1'b0);
    applyStimulus(2'd1, make_block(1'b1, 0), '0, 0, 1'b0, 1'b0);

    $display("[TB] reset mid-stream");
    applyStimulus(2'd2, make_block(1'b1, 0), '0, 0, 1'b0, 1'b1);
    applyStimulus(2'd2, make_block(1'b1, 0), '0, 0, 1'b0, 1'b0);

    $display("[TB] back-to-back polynomials");
    rdy_mode = 2;
    for (int p = 0; p < 50; p++) begin
      b0 = make_block(1'b1, 0);
      b1 = make_block(1'b1, 0);
      applyStimulus((p % 2 == 0) ? 2'd2 : 2'd3, b0, b1, $urandom_range(0, 3), 1'b0, 1'b0);
    end

    repeat (4) @(posedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
